// File: rtl/ccff_cfg_pkg.sv
// Shared definitions for the configuration-chain loader and its readback logic.
// Contents: the loader state enum, the CRC-16-CCITT constants, and a
// single-step CRC update used by every bit-serial CRC in the config path.
package ccff_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // One bit of CRC-16-CCITT, MSB-first register with the input folded at the top.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (crc_out <- CRC16_INIT)
//   enable   in   fold bit_in into the CRC on this edge
//   clear    in   reload CRC16_INIT on this edge (wins over enable)
//   bit_in   in   serial data bit
//   crc_out  out  current CRC register
module ccff_crc16_serial
    import ccff_cfg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        clear,
    input  logic        bit_in,
    output logic [15:0] crc_out
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            crc_out <= CRC16_INIT;
        end else if (enable) begin
            crc_out <= crc16_step(crc_out, bit_in);
        end
    end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain driver. Takes bitstream words over valid/ready,
// serialises them LSB-first onto ccff_head while raising ccff_clk_en, and
// folds the displaced chain contents from ccff_tail into a CRC-16.
// Ports:
//   prog_clk, prog_reset          clock and synchronous active-high reset
//   start, abort                  begin a load (IDLE only) / end it early
//   bitstream_data/valid/ready    word input handshake
//   ccff_head, ccff_tail          serial data into / out of the chain
//   ccff_clk_en                   chain shifts on edges where this is 1
//   busy, done, aborted           status; done pulses in the final cycle
//   tail_crc                      CRC of ccff_tail bits from the last load
module ccff_bitstream_loader
    import ccff_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 32,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] bitstream_data,
    input  logic              bitstream_valid,
    output logic              bitstream_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_clk_en,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [15:0]       tail_crc
);

    localparam int WB_W = $clog2(WORD_W + 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  rem_bits;
    logic [WB_W-1:0]   word_bits;
    logic [WORD_W-1:0] shreg;
    logic [15:0]       crc;
    logic              crc_clear;

    assign crc_clear = (state == IDLE) && start;

    // ccff_tail is captured on the same edge the chain shifts, i.e. in SHIFT.
    ccff_crc16_serial u_crc (
        .clk     (prog_clk),
        .rst     (prog_reset),
        .enable  (state == SHIFT),
        .clear   (crc_clear),
        .bit_in  (ccff_tail),
        .crc_out (crc)
    );

    // Next state and state-decoded outputs; outputs depend only on registers,
    // so ccff_clk_en and ccff_head cannot glitch from input activity.
    always_comb begin
        state_nxt       = state;
        bitstream_ready = 1'b0;
        ccff_clk_en     = 1'b0;
        ccff_head       = 1'b0;
        busy            = (state != IDLE);
        done            = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                bitstream_ready = 1'b1;
                if (abort)                state_nxt = FIN;
                else if (bitstream_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                ccff_clk_en = 1'b1;
                ccff_head   = shreg[0];
                // Chain length takes priority: leftover word bits are dropped.
                if (abort)                          state_nxt = FIN;
                else if (rem_bits == CNT_W'(1))     state_nxt = FIN;
                else if (word_bits == WB_W'(1))     state_nxt = LOAD;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state     <= IDLE;
            rem_bits  <= '0;
            word_bits <= '0;
            shreg     <= '0;
            aborted   <= 1'b0;
            tail_crc  <= CRC16_INIT;
        end else begin
            state <= state_nxt;
            if (crc_clear) begin
                rem_bits <= CNT_W'(CHAIN_LEN);
                aborted  <= 1'b0;
            end
            if ((state == LOAD) && bitstream_valid) begin
                shreg     <= bitstream_data;
                word_bits <= WB_W'(WORD_W);
            end
            if (state == SHIFT) begin
                shreg     <= shreg >> 1;
                word_bits <= word_bits - WB_W'(1);
                rem_bits  <= rem_bits - CNT_W'(1);
            end
            if (((state == LOAD) || (state == SHIFT)) && abort) begin
                aborted <= 1'b1;
            end
            // The last tail bit lands in crc on the edge entering FIN.
            if (state == FIN) begin
                tail_crc <= crc;
            end
        end
    end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: a 32-bit and a 20-bit chain instance, each
// with a behavioural chain model feeding ccff_tail.
module tb_ccff_bitstream_loader;

    logic        prog_clk = 1'b0;
    logic        prog_reset;
    logic        start_s [2];
    logic        abort_s [2];
    logic        valid_s [2];
    logic [7:0]  data_s  [2];
    logic        ready_s [2];
    logic        head_s  [2];
    logic        tail_s  [2];
    logic        en_s    [2];
    logic        busy_s  [2];
    logic        done_s  [2];
    logic        abt_s   [2];
    logic [15:0] crc_s   [2];

    logic [31:0] chain_a = '0;
    logic [19:0] chain_b = '0;

    int total = 0;
    int bad   = 0;

    always #5 prog_clk = ~prog_clk;

    ccff_bitstream_loader #(.CHAIN_LEN(32), .WORD_W(8)) dut_a (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start_s[0]), .abort(abort_s[0]),
        .bitstream_data(data_s[0]), .bitstream_valid(valid_s[0]), .bitstream_ready(ready_s[0]),
        .ccff_head(head_s[0]), .ccff_tail(tail_s[0]), .ccff_clk_en(en_s[0]), .busy(busy_s[0]),
        .done(done_s[0]), .aborted(abt_s[0]), .tail_crc(crc_s[0]));

    ccff_bitstream_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut_b (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start_s[1]), .abort(abort_s[1]),
        .bitstream_data(data_s[1]), .bitstream_valid(valid_s[1]), .bitstream_ready(ready_s[1]),
        .ccff_head(head_s[1]), .ccff_tail(tail_s[1]), .ccff_clk_en(en_s[1]), .busy(busy_s[1]),
        .done(done_s[1]), .aborted(abt_s[1]), .tail_crc(crc_s[1]));

    // Chain models: head enters bit 0, tail is the far end.
    always @(posedge prog_clk) begin
        if (en_s[0]) chain_a <= {chain_a[30:0], head_s[0]};
        if (en_s[1]) chain_b <= {chain_b[18:0], head_s[1]};
    end
    assign tail_s[0] = chain_a[31];
    assign tail_s[1] = chain_b[19];

    typedef struct {
        logic [31:0] payload;
        bit          rnd;
        logic [31:0] exp_head;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [31:0] hb;
        logic [31:0] tb;
        int          nb;
        int          nhs;
        int          viol;
        int          dones;
        logic        ab;
        logic        pdone;
        logic        pbusy;
    } res_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference CRC over the first n bits of v, bit 0 first.
    function automatic logic [15:0] crc_model(input logic [31:0] v, input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            if (c[15] ^ v[i]) c = (c << 1) ^ 16'h1021;
            else              c = c << 1;
        end
        return c;
    endfunction

    function automatic logic [31:0] mask_n(input int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    endfunction

    // Runs one load on instance sel. Words are payload bytes, low byte first.
    task automatic do_load(input int sel, input logic [31:0] payload, input bit rnd,
                           input int abort_at, input int busy_start_at, output res_t r);
        int  idx;
        bit  hs;
        bit  sent_a;
        bit  sent_s;
        r = '{default: 0};
        idx = 0; sent_a = 0; sent_s = 0;
        @(negedge prog_clk);
        start_s[sel] = 1'b1;
        valid_s[sel] = 1'b0;
        @(negedge prog_clk);
        start_s[sel] = 1'b0;
        while (r.cyc < 400) begin
            if (done_s[sel]) begin
                r.dones = 1;
                r.ab    = abt_s[sel];
                break;
            end
            if (en_s[sel]) begin
                if (r.nb < 32) begin
                    r.hb[r.nb] = head_s[sel];
                    r.tb[r.nb] = tail_s[sel];
                end
                r.nb++;
            end
            if (en_s[sel] && ready_s[sel]) r.viol++;
            abort_s[sel] = 1'b0;
            start_s[sel] = 1'b0;
            if (abort_at >= 0 && en_s[sel] && r.nb == abort_at && !sent_a) begin
                abort_s[sel] = 1'b1;
                sent_a = 1;
            end
            if (busy_start_at >= 0 && en_s[sel] && r.nb == busy_start_at && !sent_s) begin
                start_s[sel] = 1'b1;
                sent_s = 1;
            end
            data_s[sel]  = (idx < 4) ? payload[8*idx +: 8] : 8'h00;
            valid_s[sel] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            hs = valid_s[sel] && ready_s[sel];
            @(negedge prog_clk);
            r.cyc++;
            if (hs) begin
                idx++;
                r.nhs++;
            end
        end
        start_s[sel] = 1'b0;
        abort_s[sel] = 1'b0;
        valid_s[sel] = 1'b0;
        if (r.dones == 0) check("load_timeout", 32'd1, 32'd0);
        @(negedge prog_clk);
        r.pdone = done_s[sel];
        r.pbusy = busy_s[sel];
    endtask

    vec_t        vec [8];
    res_t        r;
    logic [31:0] prev_a;
    logic [31:0] pl;
    int          n;

    initial begin
        for (int s = 0; s < 2; s++) begin
            start_s[s] = 0; abort_s[s] = 0; valid_s[s] = 0; data_s[s] = 0;
        end
        prog_reset = 1'b1;
        repeat (3) @(negedge prog_clk);

        // Reset state.
        check("rst_ready", {31'd0, ready_s[0]}, 32'd0);
        check("rst_clk_en", {31'd0, en_s[0]}, 32'd0);
        check("rst_head", {31'd0, head_s[0]}, 32'd0);
        check("rst_busy", {31'd0, busy_s[0]}, 32'd0);
        check("rst_done", {31'd0, done_s[0]}, 32'd0);
        check("rst_aborted", {31'd0, abt_s[0]}, 32'd0);
        check("rst_crc", {16'd0, crc_s[0]}, 32'h0000_FFFF);
        prog_reset = 1'b0;

        // Vector table: fixed patterns then random payloads.
        vec[0] = '{32'h01FF_3CA5, 1'b0, 32'h01FF_3CA5};
        vec[1] = '{32'h01FF_3CA5, 1'b1, 32'h01FF_3CA5};
        vec[2] = '{32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
        vec[3] = '{32'h0000_0000, 1'b0, 32'h0000_0000};
        for (int i = 4; i < 8; i++) begin
            pl = $urandom;
            vec[i] = '{pl, (i % 2) == 1, pl & mask_n(32)};
        end

        prev_a = 32'h0;
        for (int i = 0; i < 8; i++) begin
            do_load(0, vec[i].payload, vec[i].rnd, -1, -1, r);
            check($sformatf("v%0d_head", i), r.hb, vec[i].exp_head);
            check($sformatf("v%0d_nbits", i), r.nb, 32);
            check($sformatf("v%0d_words", i), r.nhs, (32 + 7) / 8);
            if (!vec[i].rnd) check($sformatf("v%0d_cycles", i), r.cyc, 32 + (32 + 7) / 8);
            check($sformatf("v%0d_aborted", i), {31'd0, r.ab}, 32'd0);
            check($sformatf("v%0d_en_in_load", i), r.viol, 0);
            check($sformatf("v%0d_tail", i), r.tb, prev_a);
            check($sformatf("v%0d_crc", i), {16'd0, crc_s[0]}, {16'd0, crc_model(prev_a, 32)});
            check($sformatf("v%0d_busy_after", i), {31'd0, r.pbusy}, 32'd0);
            prev_a = vec[i].payload;
        end

        // 20-bit chain: third word only partly shifted.
        do_load(1, 32'h00AB_F00F, 1'b0, -1, -1, r);
        check("b_head", r.hb & mask_n(20), 32'h00AB_F00F & mask_n(20));
        check("b_nbits", r.nb, 20);
        check("b_words", r.nhs, (20 + 7) / 8);
        check("b_cycles", r.cyc, 20 + (20 + 7) / 8);
        check("b_crc", {16'd0, crc_s[1]}, {16'd0, crc_model(32'h0, 20)});

        // Abort after 13 enabled cycles.
        pl = $urandom;
        do_load(0, pl, 1'b0, 13, -1, r);
        check("abort_nbits", r.nb, 13);
        check("abort_head", r.hb & mask_n(13), pl & mask_n(13));
        check("abort_done", r.dones, 1);
        check("abort_flag", {31'd0, r.ab}, 32'd1);
        check("abort_done_once", {31'd0, r.pdone}, 32'd0);
        check("abort_busy_after", {31'd0, r.pbusy}, 32'd0);
        check("abort_held", {31'd0, abt_s[0]}, 32'd1);
        do_load(0, 32'h1234_5678, 1'b0, -1, -1, r);
        check("after_abort_flag", {31'd0, r.ab}, 32'd0);
        check("after_abort_nbits", r.nb, 32);
        check("after_abort_head", r.hb, 32'h1234_5678);

        // start while busy must not restart the load.
        do_load(0, 32'hCAFE_F00D, 1'b0, -1, 5, r);
        check("busy_start_nbits", r.nb, 32);
        check("busy_start_cycles", r.cyc, 36);
        check("busy_start_head", r.hb, 32'hCAFE_F00D);

        // Reset in the middle of SHIFT.
        @(negedge prog_clk);
        start_s[0] = 1'b1;
        @(negedge prog_clk);
        start_s[0] = 1'b0;
        valid_s[0] = 1'b1;
        data_s[0]  = 8'h5A;
        n = 0;
        for (int k = 0; k < 100 && n < 10; k++) begin
            @(negedge prog_clk);
            if (en_s[0]) n++;
        end
        check("mid_reset_reached_shift", n, 10);
        prog_reset = 1'b1;
        @(negedge prog_clk);
        check("mid_rst_clk_en", {31'd0, en_s[0]}, 32'd0);
        check("mid_rst_ready", {31'd0, ready_s[0]}, 32'd0);
        check("mid_rst_head", {31'd0, head_s[0]}, 32'd0);
        check("mid_rst_busy", {31'd0, busy_s[0]}, 32'd0);
        check("mid_rst_done", {31'd0, done_s[0]}, 32'd0);
        check("mid_rst_crc", {16'd0, crc_s[0]}, 32'h0000_FFFF);
        prog_reset = 1'b0;
        valid_s[0] = 1'b0;
        repeat (2) @(negedge prog_clk);
        check("post_rst_idle", {31'd0, busy_s[0]}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Configuration-chain driver placed upstream of the tile configuration chain (ccff_head → … → ccff_tail).
- Accepts bitstream words from the configuration port over a valid/ready handshake and serialises them LSB-first onto ccff_head.
- Generates the shift-enable that gates prog_clk into the fabric.
- Reads back the displaced chain contents from ccff_tail into a CRC-16 for load verification.

Parameters:
- CHAIN_LEN, 32, total flip-flops in the driven chain; minimum 1. The default covers one switch block: 2×4-bit size10 muxes plus 12×2-bit size2 muxes.
- WORD_W, 8, bitstream word width; 2 to 32.
- CNT_W, $clog2(CHAIN_LEN+1), width of the remaining-bit counter.

Ports:
- prog_clk  in  1  configuration clock; all logic on the rising edge.
- prog_reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a load. Ignored unless state is IDLE.
- abort  in  1  ends the load; takes effect at the next edge.
- bitstream_data  in  WORD_W  next config word; bit 0 is shifted first.
- bitstream_valid  in  1  bitstream_data is valid.
- bitstream_ready  out  1  word accepted when valid && ready.
- ccff_head  out  1  serial data into the chain.
- ccff_tail  in  1  serial data out of the chain.
- ccff_clk_en  out  1  gates prog_clk to the chain; the chain shifts on an edge where this is 1.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a load completes or aborts.
- aborted  out  1  qualifies done; 1 when the load ended by abort. Held until the next start.
- tail_crc  out  16  CRC of the ccff_tail bits captured in the most recent load.

Behaviour:
- Reset values:
  - state IDLE.
  - bitstream_ready, ccff_clk_en, ccff_head, busy, done, aborted all 0.
  - tail_crc 16'hFFFF; shift register and counters 0.
- FSM states: IDLE, LOAD, SHIFT, FIN.
- IDLE:
  - on start: go to LOAD; rem_bits ← CHAIN_LEN; crc ← 16'hFFFF; aborted ← 0.
- LOAD:
  - bitstream_ready = 1 and ccff_clk_en = 0.
  - on valid && ready: shreg ← bitstream_data; word_bits ← WORD_W; go to SHIFT.
  - without valid: stay in LOAD indefinitely; no timeout.
- SHIFT:
  - ccff_clk_en = 1, bitstream_ready = 0, ccff_head = shreg[0] (combinational from the register).
  - each cycle: shreg >>= 1; word_bits−−; rem_bits−−.
  - each cycle, ccff_tail is folded into the CRC (below).
  - leaving SHIFT, checked in priority order:
    1. rem_bits==1 (last chain bit this cycle): go to FIN. Any unshifted bits of the current word are discarded.
    2. Else word_bits==1: go to LOAD.
- Per-word cost: one LOAD bubble cycle plus WORD_W shift cycles.
- FIN:
  - ccff_clk_en = 0; tail_crc ← crc; done = 1 for this cycle.
  - go to IDLE next cycle.
- CRC-16-CCITT, bit-serial:
  - fb = crc[15] ^ ccff_tail.
  - crc ← {crc[14:0],1'b0} ^ (fb ? 16'h1021 : 16'h0000).
  - ccff_tail is sampled on the same edge on which the chain shifts.
- Exactly CHAIN_LEN enabled cycles per completed load. The number of words consumed is ceil(CHAIN_LEN/WORD_W).
- abort in LOAD or SHIFT:
  - next state FIN with aborted ← 1; ccff_clk_en drops at that edge.
  - tail_crc is still updated with the partial CRC.
  - abort in IDLE or FIN has no effect.
- start and abort in the same cycle while IDLE: start wins; abort is ignored.
- start while busy: ignored.
- prog_reset has priority over everything:
  - mid-load: IDLE on the next edge and ccff_clk_en=0.
  - the chain is left partially shifted; no recovery is attempted.
- ccff_clk_en and ccff_head are registered-state decodes; no glitches.
- Clock-gate insertion is outside this block.

Decomposition:
- Shared package ccff_cfg_pkg:
  - state enum (IDLE/LOAD/SHIFT/FIN).
  - CRC16_POLY=16'h1021 and CRC16_INIT=16'hFFFF.
  - function crc16_step(crc, bit).
- One sub-module: ccff_crc16_serial (enable, clear, bit_in, crc_out), reused by the future readback checker.

Test Plan:
1. CHAIN_LEN=32, WORD_W=8; start, words 8'hA5, 8'h3C, 8'hFF, 8'h01 with valid always high.
   - ccff_head in enabled cycles = 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1×8, 1,0,0,0,0,0,0,0.
   - 32 enabled cycles; done exactly 36 cycles after LOAD is entered; aborted=0.
2. CHAIN_LEN=20, WORD_W=8; words 8'h0F, 8'hF0, 8'hAB.
   - 3 handshakes; 20 enabled cycles.
   - Only the low nibble of 8'hAB shifted (1,1,0,1); FIN directly after.
3. Chain modelled as a 32-bit shift register; load P=32'hDEADBEEF, then load 32'h0.
   - Second load's tail bits equal P.
   - tail_crc equals the model's crc16 over P's bits.
4. valid toggled 0/1 randomly during LOAD.
   - Identical ccff_head enabled-bit sequence to scenario 1.
   - ccff_clk_en never 1 while in LOAD.
5. abort asserted after 13 enabled cycles.
   - ccff_clk_en low from the next edge; done pulses once with aborted=1; busy low the cycle after.
   - A later start completes normally with aborted=0.
6. prog_reset asserted mid-SHIFT, and start asserted while busy.
   - Reset: IDLE next edge; all outputs at reset values; tail_crc=16'hFFFF.
   - start while busy: no restart; rem_bits unaffected.
